// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction-fetch
// port and the data port. It alternates grants on conflict, registers the winning
// transaction onto the bus, and waits for an active-low acknowledge. Completion
// pulses a ready to the winner. A transaction with no acknowledge within TIMEOUT
// busy cycles is aborted and reported as a bus error.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction-fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  // Data port
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  // External memory bus
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  input  logic        bus_ack_n,
  // Hazard and exception reporting
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {
    IDLE,
    IBUSY,
    DBUSY
  } state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic          last_d;   // 1 when the most recent grant went to the data port
  logic [TW-1:0] wait_cnt; // busy cycles seen without an acknowledge

  // Data port wins a conflict unless it won the previous grant.
  logic grant_d;
  assign grant_d = d_req && (!i_req || !last_d);

  // Stalls hold the pipeline until the port's ready pulse arrives.
  assign stall_if  = i_req & ~i_ready;
  assign stall_mem = d_req & ~d_ready;

  // Arbitration, bus transaction tracking and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      wait_cnt  <= '0;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_size  <= 2'b00;
      bus_addr  <= '0;
      bus_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      // NOTE: the pulse outputs default low here and a later non-blocking
      // assignment in the same pass overrides it, so each pulse lasts one cycle.
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      bus_err <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_d) begin
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            bus_write <= d_write;
            bus_size  <= d_size;
            bus_req   <= 1'b1;
            last_d    <= 1'b1;
            wait_cnt  <= '0;
            state     <= DBUSY;
          end else if (i_req) begin
            bus_addr  <= i_addr;
            bus_write <= 1'b0;
            bus_size  <= 2'b00;
            bus_req   <= 1'b1;
            last_d    <= 1'b0;
            wait_cnt  <= '0;
            state     <= IBUSY;
          end
        end

        IBUSY, DBUSY: begin
          if (!bus_ack_n) begin
            // Acknowledged: hand the read data to the owner of the transaction.
            if (state == IBUSY) begin
              i_rdata <= bus_rdata;
              i_ready <= 1'b1;
            end else begin
              if (!bus_write) begin
                d_rdata <= bus_rdata;
              end
              d_ready <= 1'b1;
            end
            bus_req <= 1'b0;
            state   <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            // No acknowledge in time: abort, report, and release the requester
            // with zeroed read data so the pipeline can take the exception.
            if (state == IBUSY) begin
              i_rdata <= '0;
              i_ready <= 1'b1;
            end else begin
              if (!bus_write) begin
                d_rdata <= '0;
              end
              d_ready <= 1'b1;
            end
            bus_err  <= 1'b1;
            err_addr <= bus_addr;
            bus_req  <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. A transaction-level reference model
// (who wins, how many bus cycles elapse, what each port receives) predicts every
// output each cycle. Inputs change and outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_req;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic        bus_ack_n;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;
  logic [31:0] err_addr;

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_write   (d_write),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_req   (bus_req),
    .bus_write (bus_write),
    .bus_size  (bus_size),
    .bus_ack_n (bus_ack_n),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the transaction in flight and what each port has received.
  bit          m_busy, m_port_d, m_last_d;
  int          m_cnt, m_wait;
  logic        m_req, m_write, m_iready, m_dready, m_err;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata, m_err_addr;

  // Stimulus controls.
  int          wait_q[$];   // acknowledge wait states for upcoming transactions
  bit          obs_w[$];    // bus_write seen at each new bus transaction
  logic        prev_bus_req = 1'b0;
  bit          auto_mode = 1'b0;
  bit          i_keep = 1'b0;
  bit          d_keep = 1'b0;
  bit          rdata_fix_en = 1'b1;
  logic [31:0] rdata_fix = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_port_d = 0; m_last_d = 0; m_cnt = 0; m_wait = 0;
    m_req = 0; m_write = 0; m_size = 0; m_addr = 0; m_wdata = 0;
    m_irdata = 0; m_drdata = 0; m_iready = 0; m_dready = 0;
    m_err = 0; m_err_addr = 0;
  endtask

  // Release the owner of the finished transaction; data is zero on an abort.
  task automatic finish_txn(input bit aborted);
    if (m_port_d) begin
      m_dready = 1;
      if (!m_write) m_drdata = aborted ? 32'h0 : bus_rdata;
    end else begin
      m_iready = 1;
      m_irdata = aborted ? 32'h0 : bus_rdata;
    end
    if (aborted) begin
      m_err      = 1;
      m_err_addr = m_addr;
    end
    m_req  = 0;
    m_busy = 0;
  endtask

  // One clock cycle: advance the model over the rising edge just passed,
  // compare every output, then drive the memory and requesters.
  task automatic step();
    bit gd;
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_iready = 0; m_dready = 0; m_err = 0;
      if (m_busy) begin
        if (!bus_ack_n)           finish_txn(1'b0);
        else if (m_cnt == TIMEOUT) finish_txn(1'b1);
        else                      m_cnt++;
      end else if (i_req || d_req) begin
        gd = d_req && (!i_req || !m_last_d);
        m_last_d = gd; m_port_d = gd; m_busy = 1; m_cnt = 1; m_req = 1;
        if (gd) begin
          m_addr = d_addr; m_wdata = d_wdata; m_write = d_write; m_size = d_size;
        end else begin
          m_addr = i_addr; m_write = 0; m_size = 2'b00;
        end
        if (wait_q.size() > 0) m_wait = wait_q.pop_front();
        else if (auto_mode)    m_wait = ($urandom % 10 == 0) ? TIMEOUT + 3 : $urandom_range(0, 4);
        else                   m_wait = 0;
      end
    end

    if (bus_req && !prev_bus_req) obs_w.push_back(bus_write);
    prev_bus_req = bus_req;

    check("bus_req",   bus_req,   m_req);
    check("bus_write", bus_write, m_write);
    check("bus_size",  bus_size,  m_size);
    check("bus_addr",  bus_addr,  m_addr);
    check("bus_wdata", bus_wdata, m_wdata);
    check("i_ready",   i_ready,   m_iready);
    check("d_ready",   d_ready,   m_dready);
    check("i_rdata",   i_rdata,   m_irdata);
    check("d_rdata",   d_rdata,   m_drdata);
    check("bus_err",   bus_err,   m_err);
    check("err_addr",  err_addr,  m_err_addr);
    check("stall_if",  stall_if,  i_req & ~m_iready);
    check("stall_mem", stall_mem, d_req & ~m_dready);

    // Memory: acknowledge after the chosen number of wait states; while idle
    // the random phase also throws in stray acknowledges that must be ignored.
    if (m_busy && m_cnt >= m_wait + 1) bus_ack_n = 1'b0;
    else bus_ack_n = ~(auto_mode && !m_busy && ($urandom % 4 == 0));
    bus_rdata = rdata_fix_en ? rdata_fix : $urandom;

    // Requesters hold until their ready, unless told to keep requesting.
    if (i_ready && !i_keep) i_req = 1'b0;
    if (d_ready && !d_keep) d_req = 1'b0;
    if (auto_mode) begin
      if (i_req && m_busy && !m_port_d && ($urandom % 16 == 0)) i_req = 1'b0;
      if (d_req && m_busy && m_port_d && ($urandom % 16 == 0)) d_req = 1'b0;
      if (!i_req && ($urandom % 3 == 0)) begin
        i_req  = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && ($urandom % 3 == 0)) begin
        d_req   = 1'b1;
        d_write = 1'($urandom);
        d_size  = 2'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end
  endtask

  // Run until both requesters are satisfied and the bus is quiet.
  task automatic drain();
    for (int n = 0; n < 100 && (i_req || d_req || bus_req || m_busy); n++) step();
    check("drain_done", {i_req, d_req, bus_req}, 3'b000);
  endtask

  initial begin
    int          bcnt;
    bit          seen;
    bit          exp_g[4];
    model_reset();
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_write = 0; d_size = 0;
    d_addr = 0; d_wdata = 0; bus_rdata = 0; bus_ack_n = 1'b1;

    // Reset state
    #1;
    check("rst_bus_req",  bus_req,  0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_i_ready",  i_ready,  0);
    check("rst_d_ready",  d_ready,  0);
    check("rst_i_rdata",  i_rdata,  0);
    check("rst_d_rdata",  d_rdata,  0);
    check("rst_bus_err",  bus_err,  0);
    check("rst_err_addr", err_addr, 0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: single fetch acknowledged on the first bus cycle
    rdata_fix = 32'h2108_0001;
    i_req = 1'b1; i_addr = 32'h0000_0040;
    wait_q.push_back(0);
    step();
    check("t1_bus_req",   bus_req,   1);
    check("t1_bus_size",  bus_size,  2'b00);
    check("t1_bus_write", bus_write, 0);
    check("t1_bus_addr",  bus_addr,  32'h40);
    check("t1_stall_if",  stall_if,  1);
    step();
    check("t1_i_ready",   i_ready,   1);
    check("t1_i_rdata",   i_rdata,   32'h2108_0001);
    check("t1_bus_req_0", bus_req,   0);
    check("t1_stall_off", stall_if,  0);
    step();
    check("t1_pulse_end", i_ready,   0);

    // 2: held conflict alternates D, I, D, I
    obs_w.delete();
    for (int k = 0; k < 4; k++) wait_q.push_back(1);
    i_keep = 1; d_keep = 1;
    i_req = 1; i_addr = 32'h80;
    d_req = 1; d_write = 1; d_size = 2'b00; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    for (int n = 0; n < 40 && obs_w.size() < 4; n++) step();
    check("t2_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    i_keep = 0; d_keep = 0;
    drain();
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) check($sformatf("t2_grant%0d_write", k), 32'(obs_w[k]), 32'(exp_g[k]));
    check("t2_d_rdata_kept", d_rdata, 0);

    // 3: load with three wait states
    rdata_fix = 32'h1234_5678;
    wait_q.push_back(3);
    d_req = 1; d_write = 0; d_size = 2'b01; d_addr = 32'h204;
    bcnt = 0; seen = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (n == 0) check("t3_bus_size", bus_size, 2'b01);
      if (bus_req) bcnt++;
      if (i_ready) seen = 1;
      if (d_ready) break;
    end
    check("t3_bus_cycles", bcnt, 4);
    check("t3_d_ready",    d_ready, 1);
    check("t3_d_rdata",    d_rdata, 32'h1234_5678);
    check("t3_no_i_ready", 32'(seen), 0);
    step();

    // 4: timeout abort on a load, then a normal request
    wait_q.push_back(TIMEOUT + 10);
    d_req = 1; d_write = 0; d_size = 2'b10; d_addr = 32'h204;
    bcnt = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (bus_req) bcnt++;
      if (d_ready) break;
    end
    check("t4_bus_cycles", bcnt, TIMEOUT);
    check("t4_d_ready",    d_ready,  1);
    check("t4_bus_err",    bus_err,  1);
    check("t4_err_addr",   err_addr, 32'h204);
    check("t4_d_rdata",    d_rdata,  0);
    step();
    check("t4_err_pulse",  bus_err,  0);
    rdata_fix = 32'h0BAD_F00D;
    wait_q.push_back(0);
    i_req = 1; i_addr = 32'h44;
    drain();
    check("t4_next_fetch", i_rdata,  32'h0BAD_F00D);
    check("t4_err_held",   err_addr, 32'h204);

    // 5: reset in the middle of a fetch
    wait_q.push_back(5);
    i_req = 1; i_addr = 32'h300;
    step(); step();
    rst = 1'b1;
    #1;
    check("t5_async_bus_req", bus_req, 0);
    model_reset();
    d_req = 1; d_write = 0; d_size = 2'b10; d_addr = 32'h400;
    step(); step();
    rst = 1'b0;
    wait_q.push_back(0);
    step();
    check("t5_first_grant_addr", bus_addr,  32'h400);
    check("t5_first_grant_wr",   bus_write, 0);
    drain();

    // 6: fetch request dropped right after the grant still completes
    rdata_fix = 32'hCAFE_0006;
    wait_q.push_back(2);
    i_req = 1; i_addr = 32'h500;
    step();
    check("t6_granted", bus_addr, 32'h500);
    i_req = 0;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (i_ready) seen = 1;
    end
    check("t6_i_ready", 32'(seen), 1);
    check("t6_i_rdata", i_rdata, 32'hCAFE_0006);
    step();

    // Random traffic against the model
    rdata_fix_en = 0;
    auto_mode    = 1;
    for (int n = 0; n < 1500; n++) step();
    auto_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline.
- Arbitrates between the two ports, registers the selected transaction onto the bus, and waits for the active-low acknowledge.
- Returns read data to the winning port with a one-cycle ready pulse, and drives stall signals to the hazard logic.
- Aborts any transaction that is not acknowledged within TIMEOUT cycles and reports a bus error to the exception unit.

Parameters:
- TIMEOUT, 16: number of busy cycles without an acknowledge before the transaction is aborted.
- TW, 5: width of the timeout counter; TW must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high with a stable i_addr until i_ready.
- i_addr  in  32  fetch address.
- i_rdata  out  32  fetched word.
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- d_req  in  1  data request; held high with stable d_* inputs until d_ready.
- d_write  in  1  1 = store, 0 = load.
- d_size  in  2  access size, passed to the bus unchanged.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data.
- d_ready  out  1  one-cycle pulse: data access complete.
- bus_addr  out  32  registered bus address.
- bus_wdata  out  32  registered store data.
- bus_rdata  in  32  bus read data; valid when bus_ack_n is low.
- bus_req  out  1  transaction active.
- bus_write  out  1  transaction is a write.
- bus_size  out  2  transaction size; 2'b00 (word) for fetches.
- bus_ack_n  in  1  active-low acknowledge from memory.
- stall_if  out  1  i_req & ~i_ready.
- stall_mem  out  1  d_req & ~d_ready.
- bus_err  out  1  one-cycle pulse on timeout abort.
- err_addr  out  32  bus_addr of the aborted transaction; held until the next abort.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State IDLE; last_grant = I; timeout counter = 0.
  - All registered outputs = 0: bus_req, bus_write, bus_size, bus_addr, bus_wdata, i_rdata, d_rdata, i_ready, d_ready, bus_err, err_addr.
  - Any in-flight transaction is abandoned. No ready pulse and no bus_err is issued for it.
- State machine: IDLE, IBUSY, DBUSY.
- IDLE arbitration, evaluated at each clock edge:
  - Only d_req high: grant D.
  - Only i_req high: grant I.
  - Both high: grant D unless last_grant == D, in which case grant I. Conflicts therefore alternate, and D wins the first one after reset.
  - On a grant: latch the address (plus wdata/write/size for D) into the bus_* registers, set bus_req = 1, update last_grant, clear the counter, and move to IBUSY or DBUSY.
  - For an I grant: bus_write = 0 and bus_size = 2'b00.
- BUSY state, at each edge:
  - bus_ack_n low:
    - Capture bus_rdata into i_rdata (IBUSY), or into d_rdata (DBUSY, load only; d_rdata is unchanged on stores).
    - Pulse the matching ready for one cycle; bus_req = 0; go to IDLE.
  - bus_ack_n high and counter == TIMEOUT-1:
    - Abort: bus_req = 0; bus_err pulses; err_addr = bus_addr.
    - Pulse the matching ready, with rdata forced to 0 on a read; go to IDLE.
  - Otherwise: increment the counter.
  - Requester inputs are ignored while BUSY. A request dropped mid-transaction still completes, including its ready pulse.
- Latency:
  - Request high before edge k: bus_req high after edge k.
  - Ack sampled low at edge m: ready high for the cycle after edge m.
  - Minimum request-to-ready is 2 cycles.
  - One IDLE cycle always separates consecutive bus transactions; no new grant occurs on the completion edge.
- The bus_* outputs hold their values when bus_req is low and change only on a grant.
- A bus_ack_n low while in IDLE is ignored.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x0000_0040; ack_n low on the first bus_req cycle with bus_rdata=0x2108_0001 -> bus_req high 1 cycle, bus_size=00, bus_write=0; i_ready pulses with i_rdata=0x2108_0001 two cycles after the request; stall_if high only until then.
2. Conflict alternation: i_req and d_req held high together (d_write=1, d_addr=0x100, d_wdata=0xDEAD_BEEF), ack after 1 wait cycle -> grant order D, I, D, I; the store drives bus_write=1, bus_wdata=0xDEAD_BEEF; d_rdata stays unchanged.
3. Load with 3 wait states: d_req=1, d_write=0, d_size=01, d_addr=0x204 -> bus_req high 4 cycles; d_ready pulse with d_rdata = bus_rdata; i_ready stays 0.
4. Timeout: DBUSY with ack_n held high, TIMEOUT=16 -> bus_req drops after 16 busy cycles; bus_err pulses 1 cycle; err_addr=0x204; d_ready pulses with d_rdata=0; the next request is granted normally.
5. Reset mid-transaction: assert rst while in IBUSY -> bus_req=0 immediately; no i_ready; after release, the first conflict grants D.
6. Dropped request: deassert i_req one cycle after grant -> the transaction still completes and i_ready still pulses.
